// File: rtl/store_buffer.sv
// Posted-write store buffer: in-order FIFO of aligned stores drained to the data
// memory over req/ack, with youngest-entry coalescing and load-hazard detection.
module store_buffer #(
    parameter int DEPTH  = 4,
    parameter int AWIDTH = 30
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enq_valid,
    output logic                       enq_ready,
    input  logic [AWIDTH-1:0]          enq_addr,
    input  logic [31:0]                enq_data,
    input  logic [3:0]                 enq_wbe,
    output logic                       mem_req,
    output logic [AWIDTH-1:0]          mem_addr,
    output logic [31:0]                mem_din,
    output logic [3:0]                 mem_wbe,
    input  logic                       mem_ack,
    input  logic                       ld_valid,
    input  logic [AWIDTH-1:0]          ld_addr,
    output logic                       ld_hazard,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AWIDTH-1:0] addr_q [DEPTH];
    logic [AWIDTH-1:0] addr_d [DEPTH];
    logic [31:0]       data_q [DEPTH];
    logic [31:0]       data_d [DEPTH];
    logic [3:0]        wbe_q  [DEPTH];
    logic [3:0]        wbe_d  [DEPTH];
    logic [PW-1:0]     head_q, head_d;
    logic [PW-1:0]     tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;

    logic [PW-1:0]     young_s;
    logic              zero_mask_s;
    logic              coalesce_hit_s;
    logic              push_s;
    logic              pop_s;

    // Enqueue acceptance and coalesce decision, from pre-edge state only.
    always_comb begin
        young_s        = tail_q - {{(PW-1){1'b0}}, 1'b1};
        zero_mask_s    = (enq_wbe == 4'b0000);
        // With two or more entries the youngest can never be the head.
        coalesce_hit_s = (count_q >= CW'(2)) && (addr_q[young_s] == enq_addr);
        enq_ready      = (count_q < CW'(DEPTH)) || coalesce_hit_s || zero_mask_s;
        push_s         = enq_valid && enq_ready && !zero_mask_s;
        pop_s          = (count_q != {CW{1'b0}}) && mem_ack;
    end

    // Next-state: merge or append at tail, pop at head, net count update.
    always_comb begin
        addr_d  = addr_q;
        data_d  = data_q;
        wbe_d   = wbe_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push_s) begin
            if (coalesce_hit_s) begin
                for (int b = 0; b < 4; b++) begin
                    if (enq_wbe[b]) begin
                        data_d[young_s][8*b +: 8] = enq_data[8*b +: 8];
                    end else begin
                        data_d[young_s][8*b +: 8] = data_q[young_s][8*b +: 8];
                    end
                end
                wbe_d[young_s] = wbe_q[young_s] | enq_wbe;
            end else begin
                addr_d[tail_q] = enq_addr;
                data_d[tail_q] = enq_data;
                wbe_d[tail_q]  = enq_wbe;
                tail_d         = tail_q + {{(PW-1){1'b0}}, 1'b1};
            end
        end else begin
            tail_d = tail_q;
        end
        if (pop_s) begin
            head_d = head_q + {{(PW-1){1'b0}}, 1'b1};
        end else begin
            head_d = head_q;
        end
        case ({push_s && !coalesce_hit_s, pop_s})
            2'b10:   count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
            2'b01:   count_d = count_q - {{(CW-1){1'b0}}, 1'b1};
            default: count_d = count_q;
        endcase
    end

    // State registers; reset discards every pending store.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= {PW{1'b0}};
            tail_q  <= {PW{1'b0}};
            count_q <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= {AWIDTH{1'b0}};
                data_q[i] <= 32'h0000_0000;
                wbe_q[i]  <= 4'b0000;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= addr_d[i];
                data_q[i] <= data_d[i];
                wbe_q[i]  <= wbe_d[i];
            end
        end
    end

    // Drain port and status; popped slots keep stale data, so gate by mem_req.
    always_comb begin
        empty   = (count_q == {CW{1'b0}});
        count   = count_q;
        mem_req = !empty;
        if (mem_req) begin
            mem_addr = addr_q[head_q];
            mem_din  = data_q[head_q];
            mem_wbe  = wbe_q[head_q];
        end else begin
            mem_addr = {AWIDTH{1'b0}};
            mem_din  = 32'h0000_0000;
            mem_wbe  = 4'b0000;
        end
    end

    // Load hazard over pending slots: offset from head below count.
    always_comb begin
        logic [PW-1:0] off_s;
        ld_hazard = 1'b0;
        off_s     = {PW{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            off_s = PW'(i) - head_q;
            if (ld_valid && ({1'b0, off_s} < count_q) && (addr_q[i] == ld_addr)) begin
                ld_hazard = 1'b1;
            end else begin
                ld_hazard = ld_hazard;
            end
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer with hand-computed expectations.
module tb_store_buffer;

    logic        clk;
    logic        rst_n;
    logic        enq_valid;
    logic        enq_ready;
    logic [29:0] enq_addr;
    logic [31:0] enq_data;
    logic [3:0]  enq_wbe;
    logic        mem_req;
    logic [29:0] mem_addr;
    logic [31:0] mem_din;
    logic [3:0]  mem_wbe;
    logic        mem_ack;
    logic        ld_valid;
    logic [29:0] ld_addr;
    logic        ld_hazard;
    logic        empty;
    logic [2:0]  count;

    int n_cmp;
    int n_bad;

    store_buffer #(.DEPTH(4), .AWIDTH(30)) dut (
        .clk(clk), .rst_n(rst_n),
        .enq_valid(enq_valid), .enq_ready(enq_ready),
        .enq_addr(enq_addr), .enq_data(enq_data), .enq_wbe(enq_wbe),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_wbe(mem_wbe), .mem_ack(mem_ack),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_hazard(ld_hazard),
        .empty(empty), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic enq(input logic [29:0] a, input logic [31:0] d, input logic [3:0] w);
        enq_valid = 1'b1;
        enq_addr  = a;
        enq_data  = d;
        enq_wbe   = w;
        tick();
        enq_valid = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        enq_valid = 1'b0; enq_addr = 30'h0; enq_data = 32'h0; enq_wbe = 4'b0000;
        mem_ack = 1'b0; ld_valid = 1'b1; ld_addr = 30'h0;
        #12;
        check("rst_req", mem_req, 1'b0);
        check("rst_count", count, 3'd0);
        check("rst_empty", empty, 1'b1);
        check("rst_ready", enq_ready, 1'b1);
        check("rst_hazard", ld_hazard, 1'b0);
        check("rst_addr", mem_addr, 30'h0);
        ld_valid = 1'b0;
        rst_n = 1'b1;
        tick();

        // Single store then one ack
        enq(30'h4, 32'h1234_5678, 4'b1111);
        check("t1_req", mem_req, 1'b1);
        check("t1_addr", mem_addr, 30'h4);
        check("t1_din", mem_din, 32'h1234_5678);
        check("t1_wbe", mem_wbe, 4'b1111);
        check("t1_count", count, 3'd1);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("t1_empty", empty, 1'b1);
        check("t1_req0", mem_req, 1'b0);
        check("t1_addr0", mem_addr, 30'h0);
        check("t1_din0", mem_din, 32'h0);
        check("t1_wbe0", mem_wbe, 4'b0000);

        // Fill, full-buffer acceptance rules, in-order drain
        for (int i = 0; i < 4; i++) enq(30'(i), 32'hA000_0000 + 32'(i), 4'b1111);
        check("fill_count", count, 3'd4);
        enq_valid = 1'b1; enq_addr = 30'h9; enq_data = 32'h0; enq_wbe = 4'b1111;
        #1;
        check("full_ready", enq_ready, 1'b0);
        enq_wbe = 4'b0000;
        #1;
        check("zmask_ready", enq_ready, 1'b1);
        tick();
        enq_valid = 1'b0;
        check("zmask_count", count, 3'd4);
        mem_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain_req", mem_req, 1'b1);
            check("drain_addr", mem_addr, 30'(i));
            tick();
        end
        mem_ack = 1'b0;
        check("drain_empty", empty, 1'b1);

        // Coalesce behind an unacked head
        enq(30'h0, 32'hAAAA_AAAA, 4'b1111);
        enq(30'h8, 32'h0000_0078, 4'b0001);
        enq(30'h8, 32'h5678_0000, 4'b1100);
        check("co_count", count, 3'd2);
        check("co_head", mem_addr, 30'h0);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("co_addr", mem_addr, 30'h8);
        check("co_din", mem_din, 32'h5678_0078);
        check("co_wbe", mem_wbe, 4'b1101);
        check("co_count1", count, 3'd1);

        // Head protection: same address as a lone head must not merge
        enq(30'h8, 32'h0000_BB00, 4'b0010);
        check("hp_count", count, 3'd2);
        check("hp_wbe", mem_wbe, 4'b1101);
        check("hp_din", mem_din, 32'h5678_0078);
        mem_ack = 1'b1;
        tick();
        check("hp_din2", mem_din, 32'h0000_BB00);
        check("hp_wbe2", mem_wbe, 4'b0010);
        tick();
        mem_ack = 1'b0;
        check("hp_empty", empty, 1'b1);

        // Load hazard window
        enq(30'h10, 32'hDEAD_BEEF, 4'b1111);
        ld_valid = 1'b1; ld_addr = 30'h10;
        #1;
        check("hz_hit", ld_hazard, 1'b1);
        ld_addr = 30'h11;
        #1;
        check("hz_miss", ld_hazard, 1'b0);
        ld_valid = 1'b0; ld_addr = 30'h10;
        #1;
        check("hz_novalid", ld_hazard, 1'b0);
        ld_valid = 1'b1; mem_ack = 1'b1;
        #1;
        check("hz_popcycle", ld_hazard, 1'b1);
        tick();
        mem_ack = 1'b0;
        check("hz_after", ld_hazard, 1'b0);
        ld_valid = 1'b0;

        // Coalesce in the same cycle as a head pop
        enq(30'h20, 32'h1111_1111, 4'b1111);
        enq(30'h21, 32'h2222_2222, 4'b1111);
        enq_valid = 1'b1; enq_addr = 30'h21; enq_data = 32'h0000_00FF; enq_wbe = 4'b0001;
        mem_ack = 1'b1;
        tick();
        enq_valid = 1'b0; mem_ack = 1'b0;
        check("sim_count", count, 3'd1);
        check("sim_addr", mem_addr, 30'h21);
        check("sim_din", mem_din, 32'h2222_22FF);
        check("sim_wbe", mem_wbe, 4'b1111);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("sim_empty", empty, 1'b1);

        // Asynchronous reset mid-drain
        enq(30'h30, 32'h3030_3030, 4'b1111);
        enq(30'h31, 32'h3131_3131, 4'b1111);
        check("ar_req_pre", mem_req, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_req", mem_req, 1'b0);
        check("ar_count", count, 3'd0);
        check("ar_addr", mem_addr, 30'h0);
        check("ar_din", mem_din, 32'h0);
        check("ar_wbe", mem_wbe, 4'b0000);
        rst_n = 1'b1;
        tick();
        check("ar_empty", empty, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
# store_buffer

Posted-write buffer between the store-data aligner (`stx`) and the data-memory write port. Accepts aligned stores from the MEM stage: word address, shifted data, byte write-enables. Holds up to DEPTH of them in order and drains them to memory over a req/ack handshake. Merges consecutive stores to the same word and flags loads that hit a pending store, so the pipeline can stall.

## Interface
- DEPTH, 4, number of entries; power of two, ≥ 2
- AWIDTH, 30, word-address width (byte offset already consumed by `stx`)

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- enq_valid  in  1  MEM stage presents a store
- enq_ready  out  1  store accepted this cycle when high with enq_valid
- enq_addr  in  AWIDTH  word address of store
- enq_data  in  32  lane-aligned store data (`stx` dout)
- enq_wbe  in  4  byte write-enables (`stx` wbe)
- mem_req  out  1  head entry valid, write requested
- mem_addr  out  AWIDTH  head word address; 0 when mem_req low
- mem_din  out  32  head data; 0 when mem_req low
- mem_wbe  out  4  head byte enables; 0 when mem_req low
- mem_ack  in  1  memory accepts head write this cycle
- ld_valid  in  1  MEM stage is issuing a load
- ld_addr  in  AWIDTH  load word address
- ld_hazard  out  1  load hits a pending store; pipeline must stall
- empty  out  1  no pending entries
- count  out  $clog2(DEPTH)+1  number of pending entries

## Operation
- Storage is a circular FIFO: head pointer, tail pointer, count register; pointers wrap modulo DEPTH.
- Enqueue fires on enq_valid && enq_ready, at the rising edge.
- Zero-mask store (enq_wbe == 4'b0000):
  - enq_ready = 1 regardless of fullness.
  - Store is accepted and discarded; no state change.
- Coalesce hit: count ≥ 2, enq_addr equals the youngest entry's address, and the youngest entry is not the head.
  - On hit: for each byte lane i with enq_wbe[i] set, the youngest entry's byte i is replaced by enq_data byte i.
  - Youngest entry's wbe |= enq_wbe. Count unchanged.
- No hit: new entry written at tail; tail++, count++.
- enq_ready = (count < DEPTH) || coalesce_hit || (enq_wbe == 0).
  - Combinational from state and enq_addr/enq_wbe only.
  - Never depends on mem_ack, so a full buffer does not accept a non-coalescing store even in a drain cycle.
- The head entry is never modified while it is the head. This keeps mem_* stable while mem_req is high.
- Drain:
  - mem_req = !empty.
  - mem_addr, mem_din and mem_wbe come from the head register.
  - On mem_req && mem_ack: head++, count--.
  - mem_ack while mem_req low is ignored.
- Simultaneous enqueue and drain in one cycle: both apply and count is net unchanged.
  - If the enqueue coalesces, the coalesce decision uses pre-edge state. The youngest entry is not the head, so it survives the pop.
- ld_hazard = ld_valid && (any pending entry has addr == ld_addr).
  - Combinational; covers registered entries only.
  - An entry popped at this edge still counts for this cycle's hazard.
- empty = (count == 0).

## Timing
- Reset (rst_n low, asynchronous):
  - count = 0, head = tail = 0, all entries cleared.
  - mem_req = 0, mem_addr/mem_din/mem_wbe = 0, empty = 1, ld_hazard = 0, enq_ready = 1.
  - Pending stores are discarded, including a head under request.
- Reset deassertion takes effect at the next rising edge. No operation occurs on the deassertion edge itself.
- Enqueue-to-request latency into an empty buffer is 1 cycle. A store accepted at edge N gives mem_req high after edge N.
- Drain throughput is one write per cycle when mem_ack is held high.
- A store is visible to ld_hazard from the cycle after it is accepted until the cycle its pop edge completes.

## Test plan
- Reset, then enqueue addr 0x4, data 0x12345678, wbe 1111 with mem_ack low:
  - Next cycle: mem_req = 1, mem_addr = 0x4, mem_din = 0x12345678, mem_wbe = 1111, count = 1.
  - Then ack one cycle: empty = 1 and mem_* = 0.
- Fill with mem_ack low: enqueue 4 stores to addresses 0x0–0x3.
  - count = 4, enq_ready = 0 for a store to 0x9.
  - Ack held high: entries drain in order 0x0,0x1,0x2,0x3, one per cycle.
- Coalesce: with head at 0x0 (unacked), enqueue addr 0x8 data 0x00000078 wbe 0001, then addr 0x8 data 0x56780000 wbe 1100.
  - count = 2.
  - After acking the head, mem_din = 0x56780078, mem_wbe = 1101.
- Head protection: count = 1 at addr 0x8; enqueue addr 0x8 wbe 0010.
  - No merge; count = 2, head mem_wbe unchanged.
- Hazard: pending entry at 0x10; ld_valid with ld_addr 0x10 → ld_hazard = 1; ld_addr 0x11 → 0.
  - After the entry is acked, ld_addr 0x10 → 0.
- Full buffer, enq_wbe = 0000 → enq_ready = 1, count stays 4.
- Assert rst_n low mid-drain (mem_req high) → mem_req, count and mem_* go to 0 immediately, without waiting for a clock edge.
